// File: rtl/approx_or_subtractor_serial.sv
// Bit-serial approximate subtractor D = A - B, one bit per clock, LSB first.
// Index WIDTH-1 is the least significant bit; the LSB stage may be approximated by A|B.
module approx_or_subtractor_serial #(
    parameter int WIDTH     = 8,
    parameter bit APPROX_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             approx_hit
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic             hit_q, hit_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [IW-1:0]    idx_s;
    logic             abit_s, bbit_s, dbit_s, bo_s;

    // Current bit position and its subtractor stage.
    always_comb begin
        idx_s  = IW'(WIDTH - 1) - IW'(cnt_q);
        abit_s = a_q[idx_s];
        bbit_s = b_q[idx_s];
        if (cnt_q == {CW{1'b0}}) begin
            // LSB stage: borrow-in is dropped; approximate mode ORs the operands.
            if (APPROX_EN) begin
                dbit_s = abit_s | bbit_s;
            end else begin
                dbit_s = abit_s ^ bbit_s;
            end
            bo_s = ~abit_s & bbit_s;
        end else begin
            dbit_s = abit_s ^ bbit_s ^ brw_q;
            bo_s   = (~abit_s & bbit_s) | (~(abit_s ^ bbit_s) & brw_q);
        end
    end

    // Next-state and datapath updates for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        hit_d   = hit_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    d_d     = {WIDTH{1'b0}};
                    brw_d   = 1'b0;
                    hit_d   = APPROX_EN & A[WIDTH-1] & B[WIDTH-1];
                    cnt_d   = {CW{1'b0}};
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                // One extra cycle after the last bit latches the final borrow.
                if (cnt_q == CW'(WIDTH)) begin
                    bout_d  = brw_q;
                    state_d = S_DONE;
                end else begin
                    d_d[idx_s] = dbit_s;
                    brw_d      = bo_s;
                    cnt_d      = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            d_q     <= {WIDTH{1'b0}};
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            hit_q   <= 1'b0;
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE) & ~rst;
    assign out_valid  = (state_q == S_DONE);
    assign D          = d_q;
    assign Bout       = bout_q;
    assign approx_hit = hit_q;

endmodule

// File: tb/tb_approx_or_subtractor_serial.sv
// Directed and random checks of the serial approximate subtractor, approximate
// and exact instances, using a scoreboard queue of expected results.
module tb_approx_or_subtractor_serial;

    logic       clk;
    logic       rst;
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [7:0] a_s       [2];
    logic [7:0] b_s       [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [7:0] d_s       [2];
    logic       bout_s    [2];
    logic       hit_s     [2];

    typedef struct {
        logic [7:0] d;
        logic       bout;
        logic       hit;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    approx_or_subtractor_serial #(.WIDTH(8), .APPROX_EN(1'b1)) u_apx (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .A(a_s[0]), .B(b_s[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .D(d_s[0]), .Bout(bout_s[0]), .approx_hit(hit_s[0])
    );

    approx_or_subtractor_serial #(.WIDTH(8), .APPROX_EN(1'b0)) u_ex (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .A(a_s[1]), .B(b_s[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .D(d_s[1]), .Bout(bout_s[1]), .approx_hit(hit_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ports carry the MSB at index 0, so numeric values are bit-reversed.
    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    function automatic exp_t model(input bit apx, input logic [7:0] an, input logic [7:0] bn);
        exp_t e;
        logic [8:0] diff;
        diff   = {1'b0, an} - {1'b0, bn};
        e.hit  = apx & an[0] & bn[0];
        e.d    = diff[7:0] + (e.hit ? 8'd1 : 8'd0);
        e.bout = diff[8];
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input int sel, input logic [7:0] an, input logic [7:0] bn,
                          input int hold);
        int   lat;
        exp_t e;
        logic [7:0] d_hold;
        sb.push_back(model(sel == 0, an, bn));
        @(negedge clk);
        check("in_ready_before_accept", 32'(in_ready[sel]), 32'd1);
        a_s[sel]       = rev8(an);
        b_s[sel]       = rev8(bn);
        in_valid[sel]  = 1'b1;
        out_ready[sel] = (hold == 0);
        @(posedge clk);
        #1;
        in_valid[sel] = 1'b0;
        a_s[sel]      = 8'($urandom);
        b_s[sel]      = 8'($urandom);
        check("in_ready_busy", 32'(in_ready[sel]), 32'd0);
        lat = 1;
        @(posedge clk);
        #1;
        while (!out_valid[sel] && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd9);
        if (hold > 0) begin
            d_hold = d_s[sel];
            for (int i = 0; i < hold; i++) begin
                in_valid[sel] = 1'b1;
                a_s[sel]      = 8'($urandom);
                @(posedge clk);
                #1;
                check("bp_stable", {d_s[sel], 5'd0, out_valid[sel], in_ready[sel], 1'b0},
                      {d_hold, 5'd0, 1'b1, 1'b0, 1'b0});
            end
            in_valid[sel]  = 1'b0;
            out_ready[sel] = 1'b1;
        end
        e = sb.pop_front();
        check("result_d", 32'(rev8(d_s[sel])), 32'(e.d));
        check("result_bout", 32'(bout_s[sel]), 32'(e.bout));
        check("result_hit", 32'(hit_s[sel]), 32'(e.hit));
        @(posedge clk);
        #1;
        check("consumed", {out_valid[sel], in_ready[sel]}, 2'b01);
        check("idle_hold_d", 32'(rev8(d_s[sel])), 32'(e.d));
        out_ready[sel] = 1'b0;
    endtask

    initial begin
        logic [7:0] ra, rb;
        for (int s = 0; s < 2; s++) begin
            in_valid[s]  = 1'b0;
            out_ready[s] = 1'b0;
            a_s[s]       = 8'd0;
            b_s[s]       = 8'd0;
        end
        rst = 1'b1;
        #12;
        check("rst_state", {d_s[0], bout_s[0], hit_s[0], out_valid[0], in_ready[0]}, 12'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(in_ready[0]), 32'd1);

        run_op(0, 8'd5, 8'd3, 0);
        run_op(0, 8'd3, 8'd5, 0);
        run_op(0, 8'd4, 8'd1, 0);
        run_op(0, 8'd0, 8'd1, 0);
        run_op(1, 8'd5, 8'd3, 0);
        run_op(0, 8'd200, 8'd77, 20);

        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(1, ra, rb, 0);
        end
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom) | 8'd1;
            rb = 8'($urandom) | 8'd1;
            run_op(0, ra, rb, 0);
        end

        // Reset in the 4th SHIFT cycle aborts the operation.
        @(negedge clk);
        a_s[0]      = rev8(8'd255);
        b_s[0]      = rev8(8'd0);
        in_valid[0] = 1'b1;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_d_nonzero", 32'(d_s[0] != 8'd0), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_clear", {d_s[0], bout_s[0], hit_s[0], out_valid[0], in_ready[0]}, 12'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk);
                #1;
                if (out_valid[0]) seen++;
            end
            check("no_valid_after_abort", 32'(seen), 32'd0);
        end
        run_op(0, 8'd9, 8'd2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/approx_or_subtractor_serial.md
# approx_or_subtractor_serial

Bit-serial approximate subtractor computing D = A − B one bit per clock, for the difference stages of the Laplace filter datapath. It is the subtracting counterpart of the combinational approximate OR adder family. The least significant stage is approximated by OR-ing the operand bits, and the borrow into it is dropped. All higher stages are exact full subtractors with a rippling borrow. Operands enter and results leave through valid/ready handshakes.

## Interface
- WIDTH, 8, operand and result width (≥ 2).
- APPROX_EN, 1, 1 = approximate LSB stage; 0 = exact LSB stage (borrow-in 0), used as the golden-mode check.
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  A and B are presented.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- out_valid  output  1  D, Bout and approx_hit are valid.
- out_ready  input  1  consumer takes the result.
- D  output  WIDTH  difference.
- Bout  output  1  borrow out of the most significant stage.
- approx_hit  output  1  the approximation changed the result for this operation.

## Operation
- Bit ordering is fixed for the adder family. Index WIDTH−1 is the least significant bit and index 0 is the most significant. Numeric value = Σ X[i]·2^(WIDTH−1−i).
- LSB stage (index WIDTH−1), when APPROX_EN=1:
  - D[WIDTH−1] = A|B.
  - Borrow out = ~A & B.
- LSB stage when APPROX_EN=0: exact, d = A^B, borrow out = ~A & B.
- Stages WIDTH−2 down to 0 are exact:
  - d = a^b^bin.
  - bout = (~a&b) | (~(a^b)&bin).
- Bout is the borrow out of index 0.
- approx_hit = APPROX_EN & A[WIDTH−1] & B[WIDTH−1]. When it is set, the result is exactly 1 greater than the exact D (mod 2^WIDTH) and Bout equals the exact borrow.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid & in_ready, capture A and B into shift registers, clear D and the borrow register, compute approx_hit, clear the bit counter, go to SHIFT.
  - SHIFT: each cycle, process the bit at index WIDTH−1−cnt, write it into D at that index, update the borrow register, then cnt++. After WIDTH cycles, latch Bout and go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Input capture: A and B are sampled only on the accept edge. Later changes to the inputs have no effect.
- Output stability: D, Bout and approx_hit are stable throughout DONE. In IDLE they hold the last result until the next accept.
- No overlap: in_ready=0 in SHIFT and DONE, so a new operation cannot start until the result has been consumed.

## Timing
- Reset, asynchronous, all registers cleared:
  - State = IDLE.
  - D = 0, Bout = 0, approx_hit = 0, out_valid = 0.
  - in_ready = 0 while rst is high, then 1 once rst is released.
- Reset asserted during SHIFT or DONE aborts the operation and discards the result. No out_valid pulse follows.
- Latency: operands accepted at edge k give out_valid=1 after edge k+WIDTH+1. With out_ready held high, the next accept can occur at edge k+WIDTH+3.
- Back-pressure: with out_ready low, the block stays in DONE indefinitely with outputs held.
- out_ready has no effect outside DONE. in_valid has no effect outside IDLE.

## Test plan
- WIDTH=8, APPROX_EN=1, A=5, B=3 -> D=3, Bout=0, approx_hit=1 (exact result 2). out_valid rises 9 cycles after the accept edge.
- A=3, B=5 -> D=255, Bout=1, approx_hit=1 (exact result 254, borrow 1).
- A=4, B=1 -> D=3, Bout=0, approx_hit=0. A=0, B=1 -> D=255, Bout=1, approx_hit=0. Both match exact subtraction.
- APPROX_EN=0, A=5, B=3 -> D=2, Bout=0, approx_hit=0. Run a random sweep against the A−B mod 256 reference model.
- Back-pressure: hold out_ready=0 for 20 cycles in DONE -> D and out_valid stable, in_ready=0, and in_valid pulses are ignored.
- Assert rst at the 4th SHIFT cycle -> out_valid, D, Bout and approx_hit become 0 immediately. After release, A=9, B=2 completes normally with D=7, Bout=0.
